// File: rtl/fpi2c_target.sv
`default_nettype none
// ============================================================================
// Module   : fpi2c_target
// Purpose  : I2C target emulating an 8-bit register file for in-fabric tests
// Revision : 1.0
// ============================================================================
module fpi2c_target #(
    parameter logic [6:0] ADDR     = 7'h20,
    parameter int         NREGLOG2 = 3,
    parameter int         FILT     = 3
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          scli,
    input  logic                          sdai,
    output logic                          sdao,
    input  logic                          hwrite,
    input  logic [NREGLOG2-1:0]           hwaddr,
    input  logic [7:0]                    hwdata,
    output logic [8*(2**NREGLOG2)-1:0]    regsout,
    output logic                          busy,
    output logic                          wrstb,
    output logic [NREGLOG2-1:0]           wridx
);
    localparam int            NREG    = 2**NREGLOG2;
    localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK, S_RDATA, S_MACK, S_PTR, S_WDATA, S_IGNORE
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA through the conditioning chain.
    logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
    logic [CW-1:0] fcnt_q [2];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q <= {sdai, scli};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CNT_MAX) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] & prev_q[0];
    assign start_det = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
    assign stop_det  = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

    state_t              state_q, state_d;
    logic [3:0]          bcnt_q, bcnt_d;
    logic [7:0]          sh_q, sh_d;
    logic                sdao_q, sdao_d, rw_q, rw_d, ptrok_q, ptrok_d;
    logic                busy_q, busy_d, wrstb_q, wrstb_d;
    logic [NREGLOG2-1:0] ptr_q, ptr_d, wridx_q, wridx_d;
    logic [7:0]          regs_q [NREG];
    logic [7:0]          rx_byte, rd_byte;
    logic                i2c_we;

    assign rx_byte = {sh_q[6:0], filt_q[1]};
    assign rd_byte = regs_q[ptr_q];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            sh_q    <= '0;
            sdao_q  <= 1'b1;
            rw_q    <= 1'b0;
            ptrok_q <= 1'b0;
            busy_q  <= 1'b0;
            wrstb_q <= 1'b0;
            ptr_q   <= '0;
            wridx_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            sdao_q  <= sdao_d;
            rw_q    <= rw_d;
            ptrok_q <= ptrok_d;
            busy_q  <= busy_d;
            wrstb_q <= wrstb_d;
            ptr_q   <= ptr_d;
            wridx_q <= wridx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        sdao_d  = sdao_q;
        rw_d    = rw_q;
        ptrok_d = ptrok_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        wridx_d = wridx_q;
        wrstb_d = 1'b0;
        i2c_we  = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            sdao_d  = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = S_ADDR;
            bcnt_d  = '0;
            sdao_d  = 1'b1;
            ptrok_d = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise && bcnt_q < 4'd8) begin
                        sh_d   = rx_byte;
                        bcnt_d = bcnt_q + 4'd1;
                        if (state_q == S_WDATA && bcnt_q == 4'd7) begin
                            i2c_we  = 1'b1;
                            wrstb_d = 1'b1;
                            wridx_d = ptr_q;
                            ptr_d   = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bcnt_q == 4'd8) begin
                        bcnt_d  = '0;
                        sdao_d  = 1'b0;
                        state_d = S_ACK;
                        if (state_q == S_ADDR) begin
                            rw_d = sh_q[0];
                            if (sh_q[7:1] == ADDR) begin
                                busy_d = 1'b1;
                            end else begin
                                busy_d  = 1'b0;
                                sdao_d  = 1'b1;
                                state_d = S_IGNORE;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d   = sh_q[NREGLOG2-1:0];
                            ptrok_d = 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (scl_fall) begin
                        sdao_d = 1'b1;
                        bcnt_d = '0;
                        if (rw_q) begin
                            sh_d    = rd_byte;
                            sdao_d  = rd_byte[7];
                            state_d = S_RDATA;
                        end else if (ptrok_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_PTR;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bcnt_q == 4'd8) begin
                            sdao_d  = 1'b1;
                            state_d = S_MACK;
                        end else begin
                            sh_d   = {sh_q[6:0], 1'b0};
                            sdao_d = sh_q[6];
                        end
                    end
                end
                S_MACK: begin
                    // bcnt 9 marks that the controller acknowledged and the pointer already moved.
                    if (scl_rise) begin
                        if (filt_q[1]) begin
                            state_d = S_IGNORE;
                        end else begin
                            ptr_d  = ptr_q + 1'b1;
                            bcnt_d = 4'd9;
                        end
                    end else if (scl_fall && bcnt_q == 4'd9) begin
                        sh_d    = rd_byte;
                        sdao_d  = rd_byte[7];
                        bcnt_d  = '0;
                        state_d = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // The I2C write is placed last so it wins a same-cycle host write.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (hwrite) regs_q[hwaddr] <= hwdata;
            if (i2c_we) regs_q[ptr_q] <= rx_byte;
        end
    end

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_regsout
            assign regsout[8*g +: 8] = regs_q[g];
        end
    endgenerate

    assign sdao  = sdao_q;
    assign busy  = busy_q;
    assign wrstb = wrstb_q;
    assign wridx = wridx_q;
endmodule
`default_nettype wire

// File: tb/tb_fpi2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpi2c_target
// Purpose  : directed bit-banged I2C controller exercising fpi2c_target
// Revision : 1.0
// ============================================================================
module tb_fpi2c_target;
    localparam int Q = 12;

    logic        CLOCK, RESET, scli, sdai, sdao, hwrite, busy, wrstb;
    logic [2:0]  hwaddr, wridx;
    logic [7:0]  hwdata;
    logic [63:0] regsout;
    logic        m_scl, m_sda, mon_en;

    int n_total, n_pass, n_fail, nstb, low_cnt;
    logic [2:0] idx_log [16];

    fpi2c_target #(.ADDR(7'h20), .NREGLOG2(3), .FILT(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .scli(scli), .sdai(sdai), .sdao(sdao),
        .hwrite(hwrite), .hwaddr(hwaddr), .hwdata(hwdata), .regsout(regsout),
        .busy(busy), .wrstb(wrstb), .wridx(wridx)
    );

    // Open-drain bus: the line is low when either side pulls it low.
    assign scli = m_scl;
    assign sdai = m_sda & sdao;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) begin
        if (wrstb === 1'b1) begin
            if (nstb < 16) idx_log[nstb] = wridx;
            nstb++;
        end
        if (mon_en && sdao !== 1'b1) low_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge CLOCK);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, input bit tog,
                             input bit collide, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            if (tog && i == 2) begin
                m_sda = ~m_sda; qwait();
                m_sda = ~m_sda; qwait();
            end
            m_sda = b[i];
            qwait();
            m_scl = 1'b1;
            if (glitch && i == 4) begin
                qwait();
                m_scl = 1'b0;
                repeat (2) @(negedge CLOCK);
                m_scl = 1'b1;
                qwait();
            end else if (collide && i == 0) begin
                repeat (5) @(negedge CLOCK);
                hwrite = 1'b1;
                @(negedge CLOCK);
                hwrite = 1'b0;
                repeat (2*Q - 6) @(negedge CLOCK);
            end else begin
                qwait(); qwait();
            end
            m_scl = 1'b0;
            qwait();
        end
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        ack = ~sdai;
        qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic recv_byte(input bit give_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; qwait();
            m_scl = 1'b1; qwait();
            b[i] = sdai;
            qwait();
            m_scl = 1'b0; qwait();
        end
        m_sda = ~give_ack; qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    initial begin
        bit         ack;
        logic [7:0] rb;
        n_total = 0; n_pass = 0; n_fail = 0; nstb = 0; low_cnt = 0;
        m_scl = 1'b1; m_sda = 1'b1; mon_en = 1'b0;
        hwrite = 1'b0; hwaddr = '0; hwdata = '0;
        RESET = 1'b1;
        repeat (4) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);

        check("rst_sdao", sdao, 1);
        check("rst_busy", busy, 0);
        check("rst_wrstb", wrstb, 0);
        check("rst_wridx", wridx, 0);
        check("rst_regs", regsout, 0);

        // Pointer + two data writes, with an SCL glitch and SDA toggling inside the pointer byte.
        i2c_start();
        send_byte(8'h40, 0, 0, 0, ack); check("w_ack_addr", ack, 1);
        send_byte(8'h03, 1, 1, 0, ack); check("w_ack_ptr", ack, 1);
        send_byte(8'hA5, 0, 0, 0, ack); check("w_ack_d0", ack, 1);
        send_byte(8'h5A, 0, 0, 0, ack); check("w_ack_d1", ack, 1);
        check("w_busy_before_stop", busy, 1);
        i2c_stop();
        check("w_busy_after_stop", busy, 0);
        check("w_reg3", regsout[31:24], 8'hA5);
        check("w_reg4", regsout[39:32], 8'h5A);
        check("w_stb_count", nstb, 2);
        check("w_wridx0", idx_log[0], 3);
        check("w_wridx1", idx_log[1], 4);

        // Host preload, then read across the 7 -> 0 wrap.
        hwaddr = 3'd7; hwdata = 8'h11; hwrite = 1'b1;
        @(negedge CLOCK);
        hwaddr = 3'd0; hwdata = 8'h22;
        @(negedge CLOCK);
        hwrite = 1'b0;
        @(negedge CLOCK);
        check("h_reg7", regsout[63:56], 8'h11);
        check("h_reg0", regsout[7:0], 8'h22);
        i2c_start();
        send_byte(8'h40, 0, 0, 0, ack); check("r_ack_addr_w", ack, 1);
        send_byte(8'h07, 0, 0, 0, ack); check("r_ack_ptr", ack, 1);
        i2c_start();
        send_byte(8'h41, 0, 0, 0, ack); check("r_ack_addr_r", ack, 1);
        recv_byte(1, rb); check("r_byte0", rb, 8'h11);
        recv_byte(0, rb); check("r_byte1", rb, 8'h22);
        check("r_sdao_after_nack", sdao, 1);
        i2c_stop();
        check("r_busy_after_stop", busy, 0);

        // Foreign address must be ignored entirely.
        mon_en = 1'b1;
        i2c_start();
        send_byte(8'h42, 0, 0, 0, ack); check("m_ack_addr", ack, 0);
        check("m_busy", busy, 0);
        send_byte(8'hFF, 0, 0, 0, ack); check("m_ack_data", ack, 0);
        i2c_stop();
        mon_en = 1'b0;
        check("m_sdao_low_cycles", low_cnt, 0);
        check("m_regs", regsout, 64'h1100005AA5000022);
        check("m_stb_count", nstb, 2);

        // Host write of 0x77 lands in the same cycle as the I2C write of 0x99 to reg 4.
        hwaddr = 3'd4; hwdata = 8'h77;
        i2c_start();
        send_byte(8'h40, 0, 0, 0, ack); check("c_ack_addr", ack, 1);
        send_byte(8'h04, 0, 0, 0, ack); check("c_ack_ptr", ack, 1);
        send_byte(8'h99, 0, 0, 1, ack); check("c_ack_data", ack, 1);
        i2c_stop();
        check("c_regs", regsout, 64'h11000099A5000022);
        check("c_wridx", idx_log[2], 4);

        // Reset while the target drives the MSB (0) of reg[5].
        i2c_start();
        send_byte(8'h41, 0, 0, 0, ack); check("x_ack_addr", ack, 1);
        check("x_sdao_driving", sdao, 0);
        check("x_busy_before", busy, 1);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check("x_sdao_after_rst", sdao, 1);
        check("x_busy_after_rst", busy, 0);
        check("x_regs_after_rst", regsout, 0);
        hwaddr = 3'd0; hwdata = 8'h3C; hwrite = 1'b1;
        @(negedge CLOCK);
        hwrite = 1'b0;
        i2c_start();
        send_byte(8'h41, 0, 0, 0, ack); check("x_ack_addr2", ack, 1);
        recv_byte(0, rb); check("x_byte", rb, 8'h3C);
        i2c_stop();
        check("x_busy_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
